// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard / forwarding controller.
// Build option: PIPE_FWD_EN (see pipe_hazard_ctrl.sv).
package pipe_ctrl_pkg;

    // Widest register address the scoreboard can hold; narrower AW values are zero-extended.
    localparam int RD_W_MAX = 8;

    // Forward-select encoding: 0 reads the register file, k forwards from stage k.
    localparam int FWD_RF = 0;

    // One in-flight destination tracked per stage after ID.
    typedef struct packed {
        logic                valid;
        logic                regwrite;
        logic                memread;
        logic [RD_W_MAX-1:0] rd;
    } sb_entry_t;

    // Bits needed to encode a stage index 0..depth.
    function automatic int stage_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request / pipeline-control bundle between the CPU datapath (master)
// and the hazard controller (slave).
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int BR_STAGE = 2
) ();

    localparam int SW = stage_w(DEPTH);

    logic                id_valid_i;
    logic [AW-1:0]       id_rs_i;
    logic [AW-1:0]       id_rt_i;
    logic                id_use_rs_i;
    logic                id_use_rt_i;
    logic                id_regwrite_i;
    logic                id_memread_i;
    logic                id_mc_i;
    logic [AW-1:0]       id_rd_i;
    logic                br_taken_i;
    logic                pc_write_o;
    logic                ifid_write_o;
    logic                idex_bubble_o;
    logic                ex_hold_o;
    logic [BR_STAGE-1:0] flush_o;
    logic [SW-1:0]       fwd_a_o;
    logic [SW-1:0]       fwd_b_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_regwrite_i, id_memread_i, id_mc_i, id_rd_i, br_taken_i,
        input  pc_write_o, ifid_write_o, idex_bubble_o, ex_hold_o, flush_o,
               fwd_a_o, fwd_b_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_regwrite_i, id_memread_i, id_mc_i, id_rd_i, br_taken_i,
        output pc_write_o, ifid_write_o, idex_bubble_o, ex_hold_o, flush_o,
               fwd_a_o, fwd_b_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hzd_scoreboard.sv
// Shadow pipeline of in-flight destinations plus source-match priority.
// Produces the combined stall request and the forward selects for the ID
// instruction. Build option: PIPE_FWD_EN enables forwarding paths; without it
// any pending producer before the last stage stalls ID.
module hzd_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int BR_STAGE   = 2,
    localparam int SW        = stage_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          id_valid_i,
    input  logic [AW-1:0] id_rs_i,
    input  logic [AW-1:0] id_rt_i,
    input  logic          id_use_rs_i,
    input  logic          id_use_rt_i,
    input  logic          id_regwrite_i,
    input  logic          id_memread_i,
    input  logic [AW-1:0] id_rd_i,
    input  logic          enter_i,
    input  logic          hold_i,
    input  logic          flush_i,
    output logic          stall_o,
    output logic [SW-1:0] fwd_a_o,
    output logic [SW-1:0] fwd_b_o
);

    sb_entry_t [DEPTH:1]  sb_q;
    sb_entry_t [DEPTH:1]  sb_d;
    sb_entry_t            id_entry_s;
    logic [RD_W_MAX-1:0]  rs_s;
    logic [RD_W_MAX-1:0]  rt_s;
    logic [SW-1:0]        sel_a_s;
    logic [SW-1:0]        sel_b_s;
    logic                 ld_a_s;
    logic                 ld_b_s;
    logic                 load_use_s;
    logic                 no_path_s;

    assign rs_s       = RD_W_MAX'(id_rs_i);
    assign rt_s       = RD_W_MAX'(id_rt_i);
    assign id_entry_s = '{valid: id_valid_i, regwrite: id_regwrite_i,
                          memread: id_memread_i, rd: RD_W_MAX'(id_rd_i)};

    // A live producer of a non-zero register that the ID instruction really reads.
    function automatic logic src_match(input sb_entry_t e,
                                       input logic [RD_W_MAX-1:0] src,
                                       input logic use_src);
        return e.valid & e.regwrite & (e.rd != '0) & (e.rd == src) & use_src;
    endfunction

    // Advance the shadow pipeline; a flush kills everything younger than the branch.
    always_comb begin
        sb_d = '0;
        if (flush_i) begin
            sb_d[1] = '0;
        end else if (hold_i) begin
            sb_d[1] = sb_q[1];
        end else if (enter_i) begin
            sb_d[1] = id_entry_s;
        end else begin
            sb_d[1] = '0;
        end
        for (int s = 2; s <= DEPTH; s++) begin
            if (flush_i && (s <= BR_STAGE)) begin
                sb_d[s] = '0;
            end else if (hold_i && (s == 2)) begin
                sb_d[s] = '0;
            end else begin
                sb_d[s] = sb_q[s-1];
            end
        end
    end

    // Youngest matching producer per source; scanning oldest-first lets the youngest overwrite.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        ld_a_s  = 1'b0;
        ld_b_s  = 1'b0;
        for (int s = DEPTH; s >= 1; s--) begin
            sel_a_s = src_match(sb_q[s], rs_s, id_valid_i & id_use_rs_i) ? SW'(s) : sel_a_s;
            ld_a_s  = src_match(sb_q[s], rs_s, id_valid_i & id_use_rs_i) ? sb_q[s].memread : ld_a_s;
            sel_b_s = src_match(sb_q[s], rt_s, id_valid_i & id_use_rt_i) ? SW'(s) : sel_b_s;
            ld_b_s  = src_match(sb_q[s], rt_s, id_valid_i & id_use_rt_i) ? sb_q[s].memread : ld_b_s;
        end
    end

    // Stall when load data does not exist yet, or when no forwarding path can supply the value.
    always_comb begin
        load_use_s = (ld_a_s & (sel_a_s != '0) & (sel_a_s < SW'(LOAD_STAGE))) |
                     (ld_b_s & (sel_b_s != '0) & (sel_b_s < SW'(LOAD_STAGE)));
`ifdef PIPE_FWD_EN
        no_path_s = 1'b0;
        fwd_a_o   = ((sel_a_s != '0) && (sel_a_s < SW'(DEPTH))) ? (sel_a_s + SW'(1)) : SW'(FWD_RF);
        fwd_b_o   = ((sel_b_s != '0) && (sel_b_s < SW'(DEPTH))) ? (sel_b_s + SW'(1)) : SW'(FWD_RF);
`else
        no_path_s = ((sel_a_s != '0) & (sel_a_s < SW'(DEPTH))) |
                    ((sel_b_s != '0) & (sel_b_s < SW'(DEPTH)));
        fwd_a_o   = SW'(FWD_RF);
        fwd_b_o   = SW'(FWD_RF);
`endif
        stall_o = load_use_s | no_path_s;
    end

    // Scoreboard state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller for the in-order pipeline.
// Priority: taken branch > multicycle hold > load-use stall > advance.
// Build option: PIPE_FWD_EN enables forwarding; when undefined the forward
// selects stay at the register-file encoding and dependent instructions stall.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int AW         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int BR_STAGE   = 2,
    parameter int MC_LAT     = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int SW = stage_w(DEPTH);
    localparam int CW = $clog2(MC_LAT);

    logic                br_s;
    logic                hold_s;
    logic                stall_s;
    logic                enter_s;
    logic                pc_write_s;
    logic                ifid_write_s;
    logic                bubble_s;
    logic                ex_hold_s;
    logic [BR_STAGE-1:0] flush_s;
    logic [SW-1:0]       fwd_a_sel_s;
    logic [SW-1:0]       fwd_b_sel_s;
    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_d;
    logic [SW-1:0]       fwd_a_q;
    logic [SW-1:0]       fwd_a_d;
    logic [SW-1:0]       fwd_b_q;
    logic [SW-1:0]       fwd_b_d;

    // A branch seen during reset must not flush anything.
    assign br_s   = bus.br_taken_i & ~rst_i;
    assign hold_s = (cnt_q != '0);

    hzd_scoreboard #(
        .AW         (AW),
        .DEPTH      (DEPTH),
        .LOAD_STAGE (LOAD_STAGE),
        .BR_STAGE   (BR_STAGE)
    ) u_sb (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (bus.id_valid_i),
        .id_rs_i       (bus.id_rs_i),
        .id_rt_i       (bus.id_rt_i),
        .id_use_rs_i   (bus.id_use_rs_i),
        .id_use_rt_i   (bus.id_use_rt_i),
        .id_regwrite_i (bus.id_regwrite_i),
        .id_memread_i  (bus.id_memread_i),
        .id_rd_i       (bus.id_rd_i),
        .enter_i       (enter_s),
        .hold_i        (hold_s),
        .flush_i       (br_s),
        .stall_o       (stall_s),
        .fwd_a_o       (fwd_a_sel_s),
        .fwd_b_o       (fwd_b_sel_s)
    );

    // Resolve branch / hold / stall into the pipeline enables for this cycle.
    always_comb begin
        pc_write_s   = 1'b1;
        ifid_write_s = 1'b1;
        bubble_s     = 1'b0;
        ex_hold_s    = 1'b0;
        flush_s      = '0;
        enter_s      = 1'b0;
        if (br_s) begin
            flush_s = '1;
        end else if (hold_s) begin
            ex_hold_s    = 1'b1;
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
        end else if (stall_s) begin
            pc_write_s   = 1'b0;
            ifid_write_s = 1'b0;
            bubble_s     = 1'b1;
        end else begin
            enter_s = 1'b1;
        end
    end

    // Multicycle counter and EX forward selects follow whatever enters or stays in EX.
    always_comb begin
        cnt_d   = cnt_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (br_s) begin
            cnt_d   = '0;
            fwd_a_d = SW'(FWD_RF);
            fwd_b_d = SW'(FWD_RF);
        end else if (hold_s) begin
            cnt_d = cnt_q - CW'(1);
        end else if (stall_s) begin
            cnt_d   = '0;
            fwd_a_d = SW'(FWD_RF);
            fwd_b_d = SW'(FWD_RF);
        end else begin
            fwd_a_d = fwd_a_sel_s;
            fwd_b_d = fwd_b_sel_s;
            cnt_d   = (bus.id_valid_i & bus.id_mc_i) ? CW'(MC_LAT - 1) : '0;
        end
    end

    // Counter and forward-select registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            fwd_a_q <= SW'(FWD_RF);
            fwd_b_q <= SW'(FWD_RF);
        end else begin
            cnt_q   <= cnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign bus.pc_write_o    = pc_write_s;
    assign bus.ifid_write_o  = ifid_write_s;
    assign bus.idex_bubble_o = bubble_s;
    assign bus.ex_hold_o     = ex_hold_s;
    assign bus.flush_o       = flush_s;
    assign bus.fwd_a_o       = fwd_a_q;
    assign bus.fwd_b_o       = fwd_b_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations adapt to PIPE_FWD_EN.
module tb_pipe_hazard_ctrl;

    localparam int AW         = 5;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 2;
    localparam int BR_STAGE   = 2;
    localparam int MC_LAT     = 4;
`ifdef PIPE_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    pipe_hazard_ctrl_if #(.AW(AW), .DEPTH(DEPTH), .BR_STAGE(BR_STAGE)) bus ();

    pipe_hazard_ctrl #(
        .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .BR_STAGE(BR_STAGE), .MC_LAT(MC_LAT)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                         input logic urt, input logic rw, input logic mr, input logic mc,
                         input int rd);
        bus.id_valid_i    = v;
        bus.id_rs_i       = rs[AW-1:0];
        bus.id_rt_i       = rt[AW-1:0];
        bus.id_use_rs_i   = urs;
        bus.id_use_rt_i   = urt;
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
        bus.id_mc_i       = mc;
        bus.id_rd_i       = rd[AW-1:0];
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic clear();
        idle();
        repeat (DEPTH + 1) cyc();
    endtask

    // Count cycles with PC held; each must insert a bubble.
    task automatic count_stall(input string tag, input int exp);
        int n = 0;
        while (bus.pc_write_o === 1'b0 && n < 8) begin
            chk_val({tag, "_bubble"}, 32'(bus.idex_bubble_o), 32'd1);
            n++;
            cyc();
        end
        chk_val(tag, n, exp);
    endtask

    // Count multicycle hold cycles; forward selects must stay put throughout.
    task automatic count_hold(input string tag, input int exp, input int fwd_exp);
        int n = 0;
        while (bus.ex_hold_o === 1'b1 && n < 10) begin
            chk_val({tag, "_pcw"}, 32'(bus.pc_write_o), 32'd0);
            chk_val({tag, "_nobub"}, 32'(bus.idex_bubble_o), 32'd0);
            chk_val({tag, "_fwd"}, 32'(bus.fwd_a_o), fwd_exp);
            n++;
            cyc();
        end
        chk_val(tag, n, exp);
    endtask

    initial begin
        rst_i          = 1'b1;
        bus.br_taken_i = 1'b1;
        idle();
        chk_val("rst_pcw", 32'(bus.pc_write_o), 32'd1);
        chk_val("rst_ifid", 32'(bus.ifid_write_o), 32'd1);
        chk_val("rst_bubble", 32'(bus.idex_bubble_o), 32'd0);
        chk_val("rst_hold", 32'(bus.ex_hold_o), 32'd0);
        chk_val("rst_flush", 32'(bus.flush_o), 32'd0);
        chk_val("rst_fwd_a", 32'(bus.fwd_a_o), 32'd0);
        chk_val("rst_fwd_b", 32'(bus.fwd_b_o), 32'd0);
        bus.br_taken_i = 1'b0;
        repeat (2) cyc();
        rst_i = 1'b0;
        cyc();

        // Load-use: lw r8 then add r9,r8,r8
        drive(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8);
        chk_val("lw_issue", 32'(bus.pc_write_o), 32'd1);
        cyc();
        drive(1'b1, 8, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9);
        count_stall("lu_stall", (FWD != 0) ? 1 : 2);
        cyc();
        chk_val("lu_fwd_a", 32'(bus.fwd_a_o), (FWD != 0) ? 32'd3 : 32'd0);
        chk_val("lu_fwd_b", 32'(bus.fwd_b_o), (FWD != 0) ? 32'd3 : 32'd0);
        clear();

        // ALU back-to-back: add r3 ; sub r5,r3,r4
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        cyc();
        drive(1'b1, 3, 4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5);
        count_stall("b2b_stall", (FWD != 0) ? 0 : 2);
        cyc();
        chk_val("b2b_fwd_a", 32'(bus.fwd_a_o), (FWD != 0) ? 32'd2 : 32'd0);
        chk_val("b2b_fwd_b", 32'(bus.fwd_b_o), 32'd0);
        clear();

        // One-instruction gap
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        cyc();
        idle();
        cyc();
        drive(1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        count_stall("gap1_stall", (FWD != 0) ? 0 : 1);
        cyc();
        chk_val("gap1_fwd_a", 32'(bus.fwd_a_o), (FWD != 0) ? 32'd3 : 32'd0);
        clear();

        // Two-instruction gap: producer is in the last stage, RF write-through
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        cyc();
        idle();
        cyc();
        cyc();
        drive(1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5);
        count_stall("gap2_stall", 0);
        cyc();
        chk_val("gap2_fwd_a", 32'(bus.fwd_a_o), 32'd0);
        clear();

        // r0 destination never creates a dependency
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc();
        drive(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6);
        count_stall("r0_stall", 0);
        cyc();
        chk_val("r0_fwd_a", 32'(bus.fwd_a_o), 32'd0);
        chk_val("r0_fwd_b", 32'(bus.fwd_b_o), 32'd0);
        clear();

        // Multicycle: add r6 ; mul r7,r6 ; dependent on r7
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6);
        cyc();
        drive(1'b1, 6, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7);
        count_stall("mc_src_stall", (FWD != 0) ? 0 : 2);
        chk_val("mc_pre_hold", 32'(bus.ex_hold_o), 32'd0);
        cyc();
        drive(1'b1, 7, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10);
        count_hold("mc_hold", MC_LAT - 1, (FWD != 0) ? 2 : 0);
        count_stall("mc_dep_stall", (FWD != 0) ? 0 : 2);
        cyc();
        chk_val("mc_dep_fwd_a", 32'(bus.fwd_a_o), (FWD != 0) ? 32'd2 : 32'd0);
        clear();

        // Taken branch in MEM while a mc op holds EX
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc();
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7);
        cyc();
        idle();
        chk_val("brmc_pre_hold", 32'(bus.ex_hold_o), 32'd1);
        bus.br_taken_i = 1'b1;
        #1;
        chk_val("brmc_flush", 32'(bus.flush_o), 32'd3);
        chk_val("brmc_pcw", 32'(bus.pc_write_o), 32'd1);
        chk_val("brmc_ifid", 32'(bus.ifid_write_o), 32'd1);
        chk_val("brmc_hold", 32'(bus.ex_hold_o), 32'd0);
        cyc();
        bus.br_taken_i = 1'b0;
        #1;
        chk_val("brmc_cnt_clr", 32'(bus.ex_hold_o), 32'd0);
        chk_val("brmc_flush_off", 32'(bus.flush_o), 32'd0);
        clear();

        // Taken branch overrides a pending load-use stall and kills the load
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cyc();
        drive(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8);
        cyc();
        drive(1'b1, 8, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9);
        chk_val("brlu_pending", 32'(bus.pc_write_o), 32'd0);
        bus.br_taken_i = 1'b1;
        #1;
        chk_val("brlu_pcw", 32'(bus.pc_write_o), 32'd1);
        chk_val("brlu_bubble", 32'(bus.idex_bubble_o), 32'd0);
        chk_val("brlu_flush", 32'(bus.flush_o), 32'd3);
        cyc();
        bus.br_taken_i = 1'b0;
        #1;
        chk_val("brlu_load_gone", 32'(bus.pc_write_o), 32'd1);
        clear();

        // Reset in the middle of a multicycle hold
        drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7);
        cyc();
        idle();
        chk_val("rsthold_pre", 32'(bus.ex_hold_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk_val("rsthold_abort", 32'(bus.ex_hold_o), 32'd0);
        chk_val("rsthold_pcw", 32'(bus.pc_write_o), 32'd1);
        cyc();
        rst_i = 1'b0;
        cyc();
        chk_val("rsthold_after", 32'(bus.ex_hold_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
